// File: rtl/ifm_pkg.sv
// Shared state type and AXI4 constants for the instruction-memory fetch master.
package ifm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DROP
  } ifm_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
  localparam logic [3:0]  AXI_LEN_SINGLE = 4'd0;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

endpackage

// File: rtl/im_fetch_master_if.sv
// AXI4 read-address and read-data channels between the fetch master and instruction memory.
interface im_fetch_master_if #(
  parameter int ID_W = 4
);

  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;

  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/ifm_perf_cnt.sv
// Fetch and stall event counters; only built when IFM_PERF_CNT_EN is defined.
`ifdef IFM_PERF_CNT_EN
module ifm_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_pulse,
  input  logic        stall,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  // Free-running counters that simply wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_pulse) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall)       perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/im_fetch_master.sv
// Turns the IF program counter into single-beat AXI4 reads and returns the word to IF.
// Define IFM_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module im_fetch_master #(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] AXI_ID    = '0,
  parameter logic [31:0]     NOP_INSTR = ifm_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  input  logic        redirect,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_stall,
  output logic        bus_err,
`ifdef IFM_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  im_fetch_master_if.master axi
);
  import ifm_pkg::*;

  ifm_state_e  state_q, state_d;
  logic        stale_q, stale_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] instr_d;
  logic        valid_d, err_d;
  logic        last_beat;
  logic        unused_rid;

  assign unused_rid = ^axi.RID;
  assign last_beat  = axi.RVALID && axi.RLAST;

  assign axi.ARID    = AXI_ID;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARLEN   = AXI_LEN_SINGLE;
  assign axi.ARSIZE  = AXI_SIZE_WORD;
  assign axi.ARBURST = AXI_BURST_INCR;
  assign axi.ARVALID = (state_q == AR);
  assign axi.RREADY  = (state_q == R) || (state_q == DROP);

  // The delivery cycle itself releases the stall so IF captures instr_out and advances.
  assign fetch_stall = (state_q != IDLE) || (fetch_req && !instr_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stale_q     <= 1'b0;
      araddr_q    <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stale_q     <= stale_d;
      araddr_q    <= araddr_d;
      instr_out   <= instr_d;
      instr_valid <= valid_d;
      bus_err     <= err_d;
    end
  end

  // ARVALID is never withdrawn once raised; a redirect in AR only marks the read stale.
  always_comb begin
    state_d  = state_q;
    stale_d  = stale_q;
    araddr_d = araddr_q;
    instr_d  = instr_out;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req && !instr_valid && !redirect) begin
          araddr_d = {pc[31:2], 2'b00};
          state_d  = AR;
        end
      end
      AR: begin
        if (redirect) stale_d = 1'b1;
        if (axi.ARREADY) state_d = (redirect || stale_q) ? DROP : R;
      end
      R: begin
        if (last_beat) begin
          if (!redirect && !stale_q) begin
            instr_d = (axi.RRESP == AXI_RESP_OKAY) ? axi.RDATA : NOP_INSTR;
            valid_d = 1'b1;
            err_d   = (axi.RRESP != AXI_RESP_OKAY);
          end
          stale_d = 1'b0;
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (last_beat) begin
          stale_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IFM_PERF_CNT_EN
  ifm_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .fetch_pulse    (instr_valid),
    .stall          (fetch_stall),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_im_fetch_master.sv
// Scoreboard bench for im_fetch_master: a driver plays core and AXI slave, a monitor checks deliveries.
module tb_im_fetch_master;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_stall;
  logic        bus_err;
`ifdef IFM_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] held = '0;
  int          tests = 0;
  int          failures = 0;

  im_fetch_master_if #(.ID_W(4)) axi ();

  im_fetch_master dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .fetch_req      (fetch_req),
    .redirect       (redirect),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .fetch_stall    (fetch_stall),
    .bus_err        (bus_err),
`ifdef IFM_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .axi            (axi)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((axi.ARVALID || axi.RREADY || instr_valid) && n < 20) begin
      step();
      n++;
    end
    checkOutput("idle_reached", {31'b0, axi.ARVALID || axi.RREADY || instr_valid}, 32'd0);
  endtask

  // kind: 0 none, 1 redirect during AR wait, 2 redirect during R wait, 3 redirect on last beat
  task automatic applyStimulus(input logic [31:0] addr, input int ar_wait, input int r_wait,
                               input int beats, input logic [31:0] data, input logic [1:0] resp,
                               input int kind);
    logic        deliver;
    logic        last;
    logic [31:0] exp_addr;
    exp_t        e;
    deliver  = (kind == 0);
    exp_addr = {addr[31:2], 2'b00};
    waitIdle();
    pc = addr;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    checkOutput("arvalid_start", {31'b0, axi.ARVALID}, 32'd1);
    checkOutput("araddr", axi.ARADDR, exp_addr);
    checkOutput("stall_ar", {31'b0, fetch_stall}, 32'd1);
    checkOutput("ar_fixed", {21'b0, axi.ARID, axi.ARLEN, axi.ARSIZE}, {21'b0, 4'd0, 4'd0, 3'b010});
    checkOutput("arburst", {30'b0, axi.ARBURST}, 32'd1);
    for (int i = 0; i < ar_wait; i++) begin
      axi.ARREADY = 1'b0;
      redirect = (kind == 1 && i == 0);
      step();
      checkOutput("arvalid_hold", {31'b0, axi.ARVALID}, 32'd1);
      checkOutput("araddr_hold", axi.ARADDR, exp_addr);
    end
    redirect = 1'b0;
    axi.ARREADY = 1'b1;
    step();
    axi.ARREADY = 1'b0;
    checkOutput("arvalid_after_hs", {31'b0, axi.ARVALID}, 32'd0);
    checkOutput("rready", {31'b0, axi.RREADY}, 32'd1);
    for (int i = 0; i < r_wait; i++) begin
      axi.RVALID = 1'b0;
      redirect = (kind == 2 && i == 0);
      step();
      checkOutput("stall_r", {31'b0, fetch_stall}, 32'd1);
      checkOutput("rready_hold", {31'b0, axi.RREADY}, 32'd1);
    end
    redirect = 1'b0;
    for (int b = 0; b < beats; b++) begin
      last = (b == beats - 1);
      axi.RVALID = 1'b1;
      axi.RLAST  = last;
      axi.RDATA  = last ? data : $urandom;
      axi.RRESP  = last ? resp : 2'($urandom);
      axi.RID    = 4'($urandom);
      redirect   = (kind == 3) && last;
      checkOutput("rready_beat", {31'b0, axi.RREADY}, 32'd1);
      if (last) begin
        fetch_req = deliver;
        if (deliver) begin
          e.data = (resp == 2'b00) ? data : 32'h0000_0013;
          e.err  = (resp != 2'b00);
          sb.push_back(e);
        end
      end
      step();
    end
    axi.RVALID = 1'b0;
    axi.RLAST  = 1'b0;
    redirect   = 1'b0;
    checkOutput("valid_pulse", {31'b0, instr_valid}, {31'b0, deliver});
    checkOutput("stall_on_valid", {31'b0, fetch_stall}, 32'd0);
    checkOutput("rready_idle", {31'b0, axi.RREADY}, 32'd0);
    fetch_req = 1'b0;
    step();
    checkOutput("valid_one_cycle", {31'b0, instr_valid}, 32'd0);
    checkOutput("no_restart", {31'b0, axi.ARVALID}, 32'd0);
  endtask

  // Monitor: every delivery must match the oldest expected word; otherwise instr_out holds.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = '0;
      end else if (instr_valid) begin
        if (sb.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL unexpected_valid: actual instr 0x%08h, expected no delivery", instr_out);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("instr_out", instr_out, mon_e.data);
          checkOutput("bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
          held = mon_e.data;
        end
      end else begin
        checkOutput("instr_hold", instr_out, held);
        checkOutput("bus_err_idle", {31'b0, bus_err}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ar_w, r_w, nb, kind;
    logic [1:0] resp;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RLAST   = 1'b0;
    axi.RDATA   = '0;
    axi.RRESP   = '0;
    axi.RID     = '0;
    repeat (3) step();
    checkOutput("rst_arvalid", {31'b0, axi.ARVALID}, 32'd0);
    checkOutput("rst_rready", {31'b0, axi.RREADY}, 32'd0);
    checkOutput("rst_araddr", axi.ARADDR, 32'd0);
    checkOutput("rst_instr", instr_out, 32'd0);
    checkOutput("rst_valid_err", {30'b0, instr_valid, bus_err}, 32'd0);
    rst = 1'b0;
    step();

    applyStimulus(32'h0000_0100, 0, 0, 1, 32'h0000_0093, 2'b00, 0);
    applyStimulus(32'h0000_0106, 4, 3, 1, 32'h0010_0093, 2'b00, 0);
    applyStimulus(32'h0000_0108, 3, 1, 1, 32'h1111_1111, 2'b00, 1);
    applyStimulus(32'h0000_010c, 0, 1, 1, 32'hDEAD_BEEF, 2'b00, 3);
    applyStimulus(32'h0000_0110, 0, 0, 1, 32'h1234_5678, 2'b10, 0);
    applyStimulus(32'h0000_0114, 1, 2, 2, 32'h2222_2222, 2'b00, 2);
    applyStimulus(32'h0000_0118, 0, 0, 3, 32'h00C0_FFEE, 2'b00, 0);

    // Redirect in IDLE must not launch a request.
    waitIdle();
    fetch_req = 1'b1;
    redirect  = 1'b1;
    step();
    checkOutput("idle_redirect_no_ar", {31'b0, axi.ARVALID}, 32'd0);
    fetch_req = 1'b0;
    redirect  = 1'b0;
    step();

    // Reset while waiting in R, then a clean fetch.
    pc = 32'h0000_0300;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    axi.ARREADY = 1'b1;
    step();
    axi.ARREADY = 1'b0;
    checkOutput("pre_rst_in_r", {31'b0, axi.RREADY}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_arvalid_rready", {30'b0, axi.ARVALID, axi.RREADY}, 32'd0);
    checkOutput("mid_rst_araddr", axi.ARADDR, 32'd0);
    checkOutput("mid_rst_instr", instr_out, 32'd0);
    checkOutput("mid_rst_valid_err_stall", {29'b0, instr_valid, bus_err, fetch_stall}, 32'd0);
    step();
    rst = 1'b0;
    step();
    applyStimulus(32'h0000_0200, 0, 0, 1, 32'h00A0_0113, 2'b00, 0);

    for (int t = 0; t < 40; t++) begin
      ar_w = $urandom_range(0, 4);
      r_w  = $urandom_range(0, 3);
      nb   = $urandom_range(1, 3);
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = 0;
      if (kind == 1 && ar_w == 0) ar_w = 1;
      if (kind == 2 && r_w == 0) r_w = 1;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus($urandom, ar_w, r_w, nb, $urandom, resp, kind);
    end

    repeat (3) step();
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
